// File: rtl/btn_cond_pkg.sv
// rtl/btn_cond_pkg.sv - shared constants and types for the two-channel button conditioner
package btn_cond_pkg;

  localparam int CH_N              = 2;
  localparam int CNT_W             = 8;
  localparam int DEB_CYCLES_DEF    = 4;
  localparam int REPEAT_CYCLES_DEF = 16;

  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/btn_cond_ch.sv
// rtl/btn_cond_ch.sv - one channel: 2-flop sync, debounce, edge pulses
// BTN_COND_REPEAT_EN adds a per-channel auto-repeat counter on rise.
module btn_cond_ch
  import btn_cond_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
`ifdef BTN_COND_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam cnt_t DEB_LAST = cnt_t'(DEB_CYCLES - 1);

  logic r_sync1;
  logic r_sync2;
  logic r_level;
  logic r_rise;
  logic r_fall;
  cnt_t r_cnt;
  logic w_accept;
  logic w_rep_pulse;

  // Any sample agreeing with the current level restarts the run from zero.
  assign w_accept = (r_sync2 != r_level) && (r_cnt == DEB_LAST);

`ifdef BTN_COND_REPEAT_EN
  localparam cnt_t REP_LAST = cnt_t'(REPEAT_CYCLES - 1);

  cnt_t r_rep;

  assign w_rep_pulse = r_level && !w_accept && (r_rep == REP_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rep <= '0;
    end else if (w_accept || !r_level) begin
      r_rep <= '0;
    end else if (r_rep == REP_LAST) begin
      r_rep <= '0;
    end else begin
      r_rep <= r_rep + cnt_t'(1);
    end
  end
`else
  assign w_rep_pulse = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_rise  <= (w_accept && r_sync2) || w_rep_pulse;
      r_fall  <= w_accept && !r_sync2;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt   <= '0;
        r_level <= r_sync2;
      end else begin
        r_cnt <= r_cnt + cnt_t'(1);
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/btn_cond.sv
// rtl/btn_cond.sv - two-channel push-button conditioner feeding the lamp/latch set inputs
// BTN_COND_REPEAT_EN enables auto-repeat rise pulses while a button is held.
module btn_cond
  import btn_cond_pkg::*;
#(
  parameter int DEB_CYCLES    = DEB_CYCLES_DEF,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH_N-1:0] btn_i,
  output logic [CH_N-1:0] level_o,
  output logic [CH_N-1:0] rise_o,
  output logic [CH_N-1:0] fall_o
);

  if (DEB_CYCLES < 1 || DEB_CYCLES > 255) begin : g_deb_range
    $error("btn_cond: DEB_CYCLES must be 1..255");
  end
  if (REPEAT_CYCLES < 2 || REPEAT_CYCLES > 255) begin : g_rep_range
    $error("btn_cond: REPEAT_CYCLES must be 2..255");
  end

  // Channels are fully independent; the downstream latch resolves A+B itself.
  for (genvar g = 0; g < CH_N; g++) begin : g_ch
    btn_cond_ch #(
      .DEB_CYCLES   (DEB_CYCLES)
`ifdef BTN_COND_REPEAT_EN
      ,
      .REPEAT_CYCLES(REPEAT_CYCLES)
`endif
    ) u_ch (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_btn  (btn_i[g]),
      .o_level(level_o[g]),
      .o_rise (rise_o[g]),
      .o_fall (fall_o[g])
    );
  end

endmodule

// File: tb/tb_btn_cond.sv
// tb/tb_btn_cond.sv - scoreboard bench for btn_cond against a run-length reference model
module tb_btn_cond;
  import btn_cond_pkg::*;

  localparam int DEB  = DEB_CYCLES_DEF;
  localparam int REP  = REPEAT_CYCLES_DEF;
  localparam int MAXN = 8192;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] btn_i;
  logic [1:0] level_o;
  logic [1:0] rise_o;
  logic [1:0] fall_o;

  int n_checks = 0;
  int n_pass   = 0;
  bit done     = 1'b0;

  btn_cond dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .btn_i  (btn_i),
    .level_o(level_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
  endtask

  // Reference: a level flips once the last DEB synchronised samples (raw input
  // two edges earlier) all disagree with it and DEB edges have passed since the
  // previous flip or reset.
  logic [1:0] hist [0:MAXN-1];
  logic [5:0] exp_q [$];
  int         n = 0;
  int         last_flip [2];
  logic [1:0] m_level;

  always @(posedge clk) begin : model
    logic [1:0] er, ef;
    bit         flip;
    int         k;
    logic       s;
    er = '0;
    ef = '0;
    if (!rst_n) begin
      hist[n] = 2'b00;
      if (n > 0) hist[n-1] = 2'b00;
      m_level = 2'b00;
      last_flip[0] = n;
      last_flip[1] = n;
    end else begin
      hist[n] = btn_i;
      for (int c = 0; c < 2; c++) begin
        flip = 1'b0;
        if (n - last_flip[c] >= DEB) begin
          flip = 1'b1;
          for (int j = 0; j < DEB; j++) begin
            k = n - 2 - j;
            s = (k >= 0) ? hist[k][c] : 1'b0;
            if (s == m_level[c]) flip = 1'b0;
          end
        end
        if (flip) begin
          m_level[c]   = ~m_level[c];
          last_flip[c] = n;
          er[c]        = m_level[c];
          ef[c]        = ~m_level[c];
        end
`ifdef BTN_COND_REPEAT_EN
        else if (m_level[c] && ((n - last_flip[c]) % REP == 0)) begin
          er[c] = 1'b1;
        end
`endif
      end
    end
    exp_q.push_back({m_level, er, ef});
    if (n < MAXN - 1) n++;
  end

  always @(negedge clk) begin : monitor
    logic [5:0] e;
    if (!done) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 8'd0, 8'd1);
      end else begin
        e = exp_q.pop_front();
        check("sb_outputs", {2'b00, level_o, rise_o, fall_o}, {2'b00, e});
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin : stim
    int         hold [2];
    logic [1:0] b;
    int         cnt;

    btn_i = 2'b00;
    rst_n = 1'b0;
    repeat (3) step();
    check("reset_state", {2'b00, level_o, rise_o, fall_o}, 8'h00);
    rst_n = 1'b1;
    repeat (10) step();

    // Press ch0: level after E+DEB+1, rise for one cycle only.
    btn_i = 2'b01;
    repeat (DEB + 1) step();
    check("press_level_early", {6'd0, level_o}, 8'h00);
    step();
    check("press_level", {6'd0, level_o}, 8'h01);
    check("press_rise", {6'd0, rise_o}, 8'h01);
    step();
    check("press_rise_clear", {6'd0, rise_o}, 8'h00);
    repeat (24) step();
    btn_i = 2'b00;
    repeat (DEB + 2) step();
    check("release_fall", {6'd0, level_o, fall_o}, 8'h01);
    step();
    check("release_fall_clear", {6'd0, fall_o}, 8'h00);
    repeat (10) step();

    // Glitch on ch1 shorter than DEB.
    btn_i = 2'b10;
    repeat (DEB - 1) step();
    btn_i = 2'b00;
    cnt = 0;
    repeat (15) begin
      step();
      cnt += int'(level_o[1] | rise_o[1] | fall_o[1]);
    end
    check("glitch_no_activity", 8'(cnt), 8'd0);

    // Bounce then hold: exactly one rise.
    cnt = 0;
    foreach (b[i]) b[i] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      btn_i = (i % 2 == 0) ? 2'b01 : 2'b00;
      step();
      cnt += int'(rise_o[0]);
    end
    btn_i = 2'b01;
    repeat (12) begin
      step();
      cnt += int'(rise_o[0]);
    end
    check("bounce_one_rise", 8'(cnt), 8'd1);
`ifdef BTN_COND_REPEAT_EN
    btn_i = 2'b00;
    repeat (12) step();
    btn_i = 2'b01;
    cnt = 0;
    repeat (DEB + 2 + 60) begin
      step();
      cnt += int'(rise_o[0]);
      check("repeat_no_fall", {6'd0, fall_o}, 8'h00);
    end
    check("repeat_rise_count", 8'(cnt), 8'd4);
`endif
    btn_i = 2'b00;
    repeat (12) step();

    // Simultaneous press.
    btn_i = 2'b11;
    repeat (DEB + 2) step();
    check("simul_level", {6'd0, level_o}, 8'h03);
    check("simul_rise", {6'd0, rise_o}, 8'h03);
    btn_i = 2'b00;
    repeat (12) step();

    // Reset mid-count with ch1 already high.
    btn_i = 2'b10;
    repeat (DEB + 6) step();
    btn_i = 2'b11;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("reset_async_clear", {2'b00, level_o, rise_o, fall_o}, 8'h00);
    step();
    rst_n = 1'b1;
    repeat (DEB + 1) step();
    check("post_reset_early", {6'd0, level_o}, 8'h00);
    step();
    check("post_reset_level", {6'd0, level_o}, 8'h03);
    btn_i = 2'b00;
    repeat (12) step();

    // Randomised holds around the debounce threshold, with occasional resets.
    hold[0] = 0;
    hold[1] = 0;
    b = 2'b00;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int c = 0; c < 2; c++) begin
        if (hold[c] <= 0) begin
          b[c] = 1'($urandom_range(0, 1));
          case ($urandom_range(0, 5))
            0: hold[c] = 1;
            1: hold[c] = DEB - 1;
            2: hold[c] = DEB;
            3: hold[c] = DEB + 1;
            4: hold[c] = int'($urandom_range(5, 30));
            default: hold[c] = int'($urandom_range(30, 70));
          endcase
        end else begin
          hold[c]--;
        end
      end
      btn_i = b;
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      step();
    end

    btn_i = 2'b00;
    rst_n = 1'b1;
    repeat (10) step();
    done = 1'b1;
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
